req_parser: RTL and testbench

Downstream stage of the IPG request generator. It deframes the 3-beat remote-read request stream (header, source-address block, destination-address block) carried in IPG chunks into one request descriptor, and checks framing using the low tag byte. Good descriptors are buffered in a small FWFT FIFO that the memory-access engine drains with a valid/ready handshake. The input side has no backpressure: when the FIFO is full, requests are dropped and counted.

---
 rtl/edm_req_pkg.sv | 35 +++
 rtl/req_desc_fifo.sv | 64 ++++++
 rtl/req_parser.sv | 143 ++++++++++++++
 tb/tb_req_parser.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/edm_req_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edm_req_pkg
// Purpose  : Shared tags, widths, descriptor type and FSM states for req_parser
// Revision : 1.0
// ============================================================================
package edm_req_pkg;

    localparam int DATA_W = 64;
    localparam int IPG_W  = 56;
    localparam int PORT_W = 12;
    localparam int REQL_W = 8;
    localparam int FIFO_W = 2;
    localparam int CNT_W  = 16;

    localparam logic [7:0] TAG_HDR = 8'h0a;
    localparam logic [7:0] TAG_SRC = 8'h1a;
    localparam logic [7:0] TAG_DST = 8'h2a;

    typedef struct packed {
        logic [REQL_W-1:0]   len;
        logic [PORT_W/2-1:0] src_port;
        logic [PORT_W/2-1:0] dst_port;
        logic [IPG_W-1:0]    src_addr;
        logic [IPG_W-1:0]    dst_addr;
    } req_desc_t;

    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_SRC = 2'd1,
        S_DST = 2'd2
    } parse_state_t;

endpackage
`default_nettype wire

// File: rtl/req_desc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : req_desc_fifo
// Purpose  : Synchronous first-word-fall-through FIFO of request descriptors
// Revision : 1.0
// ============================================================================
module req_desc_fifo
    import edm_req_pkg::*;
#(
    parameter int AW = FIFO_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  req_desc_t     wdata_i,
    input  logic          pop_i,
    output req_desc_t     rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    req_desc_t         mem_q [2**AW];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == DEPTH);
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Head is forced to zero while empty so outputs read 0 out of reset.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/req_parser.sv
`default_nettype none
// ============================================================================
// Module   : req_parser
// Purpose  : Deframes 3-beat IPG read requests into descriptors, buffers them
// Revision : 1.0
// ============================================================================
module req_parser
    import edm_req_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int IPG_WIDTH  = IPG_W,
    parameter int PORT_WIDTH = PORT_W,
    parameter int REQL_WIDTH = REQL_W,
    parameter int FIFO_AW    = FIFO_W,
    parameter int CNT_WIDTH  = CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   ipg_req_chunk,
    input  logic                    valid_req,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [REQL_WIDTH-1:0]   req_len,
    output logic [PORT_WIDTH/2-1:0] req_src_port,
    output logic [PORT_WIDTH/2-1:0] req_dst_port,
    output logic [IPG_WIDTH-1:0]    req_src_addr,
    output logic [IPG_WIDTH-1:0]    req_dst_addr,
    output logic [FIFO_AW:0]        fifo_level,
    output logic [CNT_WIDTH-1:0]    frame_err_cnt,
    output logic [CNT_WIDTH-1:0]    drop_cnt
);

    parse_state_t           state_q, state_d;
    logic [REQL_WIDTH-1:0]  len_q, len_d;
    logic [PORT_WIDTH-1:0]  ports_q, ports_d;
    logic [IPG_WIDTH-1:0]   src_addr_q, src_addr_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q, drop_cnt_q;

    logic [7:0]             w_tag;
    logic [REQL_WIDTH-1:0]  w_hdr_len;
    logic [PORT_WIDTH-1:0]  w_hdr_ports;
    logic [IPG_WIDTH-1:0]   w_addr;
    logic                   w_err;
    logic                   w_complete;
    logic                   w_full;
    logic                   w_empty;
    req_desc_t              w_new_desc;
    req_desc_t              w_head;

    assign w_tag       = ipg_req_chunk[7:0];
    assign w_hdr_len   = ipg_req_chunk[DATA_WIDTH-1 -: REQL_WIDTH];
    assign w_hdr_ports = ipg_req_chunk[DATA_WIDTH-REQL_WIDTH-1 -: PORT_WIDTH];
    assign w_addr      = ipg_req_chunk[DATA_WIDTH-1 -: IPG_WIDTH];

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        ports_d    = ports_q;
        src_addr_d = src_addr_q;
        w_err      = 1'b0;
        w_complete = 1'b0;
        if (valid_req) begin
            // A header tag anywhere restarts the frame with the new header.
            if (w_tag == TAG_HDR) begin
                len_d   = w_hdr_len;
                ports_d = w_hdr_ports;
                state_d = S_SRC;
                w_err   = (state_q != S_HDR);
            end else begin
                case (state_q)
                    S_SRC: begin
                        if (w_tag == TAG_SRC) begin
                            src_addr_d = w_addr;
                            state_d    = S_DST;
                        end else begin
                            w_err   = 1'b1;
                            state_d = S_HDR;
                        end
                    end
                    S_DST: begin
                        w_err      = (w_tag != TAG_DST);
                        w_complete = (w_tag == TAG_DST);
                        state_d    = S_HDR;
                    end
                    default: begin
                        w_err   = 1'b1;
                        state_d = S_HDR;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HDR;
            len_q      <= '0;
            ports_q    <= '0;
            src_addr_q <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ports_q    <= ports_d;
            src_addr_q <= src_addr_d;
            if (w_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
            if (w_complete && w_full && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    always_comb begin
        w_new_desc.len      = len_q;
        w_new_desc.src_port = ports_q[PORT_WIDTH-1 -: PORT_WIDTH/2];
        w_new_desc.dst_port = ports_q[PORT_WIDTH/2-1:0];
        w_new_desc.src_addr = src_addr_q;
        w_new_desc.dst_addr = w_addr;
    end

    // Fullness is the registered count, so a same-cycle pop never makes room.
    req_desc_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_complete),
        .wdata_i (w_new_desc),
        .pop_i   (req_ready),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (fifo_level)
    );

    assign req_valid     = !w_empty;
    assign req_len       = w_head.len;
    assign req_src_port  = w_head.src_port;
    assign req_dst_port  = w_head.dst_port;
    assign req_src_addr  = w_head.src_addr;
    assign req_dst_addr  = w_head.dst_addr;
    assign frame_err_cnt = err_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_req_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_parser
// Purpose  : Scoreboard bench for req_parser with directed request frames
// Revision : 1.0
// ============================================================================
module tb_req_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] ipg_req_chunk = '0;
    logic        valid_req = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [7:0]  req_len;
    logic [5:0]  req_src_port;
    logic [5:0]  req_dst_port;
    logic [55:0] req_src_addr;
    logic [55:0] req_dst_addr;
    logic [2:0]  fifo_level;
    logic [15:0] frame_err_cnt;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_popped = 0;

    typedef struct packed {
        logic [7:0]  len;
        logic [5:0]  sp;
        logic [5:0]  dp;
        logic [55:0] sa;
        logic [55:0] da;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    req_parser dut (
        .clk           (clk),
        .rst           (rst),
        .ipg_req_chunk (ipg_req_chunk),
        .valid_req     (valid_req),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_len       (req_len),
        .req_src_port  (req_src_port),
        .req_dst_port  (req_dst_port),
        .req_src_addr  (req_src_addr),
        .req_dst_addr  (req_dst_addr),
        .fifo_level    (fifo_level),
        .frame_err_cnt (frame_err_cnt),
        .drop_cnt      (drop_cnt)
    );

    // Monitor: every accepted head descriptor is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready) begin
            exp_t act;
            exp_t exp;
            act = {req_len, req_src_port, req_dst_port, req_src_addr, req_dst_addr};
            n_checks++;
            n_popped++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL desc_unexpected: got %h, required none", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL desc: got %h, required %h", act, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] c);
        ipg_req_chunk = c;
        valid_req     = 1'b1;
        step();
        valid_req     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_req = 1'b0;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] l, input logic [5:0] s, input logic [5:0] d);
        return {l, s, d, 36'h0, 8'h0a};
    endfunction

    function automatic logic [63:0] blk(input logic [55:0] a, input logic [7:0] tag);
        return {a, tag};
    endfunction

    task automatic frame(input logic [7:0] l, input logic [5:0] s, input logic [5:0] d,
                         input logic [55:0] sa, input logic [55:0] da, input bit expect_push);
        beat(hdr(l, s, d));
        beat(blk(sa, 8'h1a));
        if (expect_push) exp_q.push_back({l, s, d, sa, da});
        beat(blk(da, 8'h2a));
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        idle(2);
        do_reset();
        chk("rst_valid", 64'(req_valid), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_err", 64'(frame_err_cnt), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_desc", {req_len, req_src_port, req_dst_port, req_src_addr[43:0]}, 64'd0);

        // Single frame: one-cycle pulse straight after the dst edge.
        req_ready = 1'b1;
        frame(8'hA0, 6'd0, 6'd5, 56'h1234, 56'h5678, 1'b1);
        chk("t1_latency", 64'(req_valid), 64'd1);
        step();
        chk("t1_pulse", 64'(req_valid), 64'd0);
        chk("t1_popped", 64'(n_popped), 64'd1);
        chk("t1_err", 64'(frame_err_cnt), 64'd0);
        chk("t1_drop", 64'(drop_cnt), 64'd0);

        // Back-to-back frames with idle gaps inside frames.
        do_reset();
        beat(hdr(8'h11, 6'h3f, 6'h01)); idle(2);
        beat(blk(56'hAAAA_0001, 8'h1a)); idle(1);
        exp_q.push_back({8'h11, 6'h3f, 6'h01, 56'hAAAA_0001, 56'hBBBB_0001});
        beat(blk(56'hBBBB_0001, 8'h2a));
        frame(8'h22, 6'h10, 6'h20, 56'hFF_FFFF_FFFF_FFFF, 56'h0, 1'b1);
        beat(hdr(8'h33, 6'h2a, 6'h15)); beat(blk(56'h3333, 8'h1a)); idle(3);
        exp_q.push_back({8'h33, 6'h2a, 6'h15, 56'h3333, 56'h4444});
        beat(blk(56'h4444, 8'h2a));
        drain("t2_drain");
        chk("t2_popped", 64'(n_popped), 64'd4);
        chk("t2_err", 64'(frame_err_cnt), 64'd0);

        // Header resync inside S_SRC.
        do_reset();
        beat(hdr(8'h01, 6'h1, 6'h1));
        beat(hdr(8'h02, 6'h2, 6'h2));
        chk("t3_err_next_edge", 64'(frame_err_cnt), 64'd1);
        frame_tail: begin
            beat(blk(56'h77, 8'h1a));
            exp_q.push_back({8'h02, 6'h2, 6'h2, 56'h77, 56'h88});
            beat(blk(56'h88, 8'h2a));
        end
        drain("t3_drain");
        chk("t3_popped", 64'(n_popped), 64'd5);
        chk("t3_err", 64'(frame_err_cnt), 64'd1);

        // Stray dst in S_HDR, bad tag in S_SRC: errors only.
        do_reset();
        beat(blk(56'h9, 8'h2a));
        beat(hdr(8'h05, 6'h5, 6'h5));
        beat(blk(56'h9, 8'h55));
        beat(blk(56'h9, 8'h2a));
        chk("t4_err", 64'(frame_err_cnt), 64'd3);
        chk("t4_level", 64'(fifo_level), 64'd0);
        chk("t4_popped", 64'(n_popped), 64'd5);

        // FIFO full: fifth dropped; sixth completes with a pop, still dropped.
        do_reset();
        req_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            frame(8'(i), 6'(i), 6'(i + 8), 56'(i * 16), 56'(i * 256), i <= 4);
        end
        chk("t5_level_full", 64'(fifo_level), 64'd4);
        chk("t5_drop1", 64'(drop_cnt), 64'd1);
        beat(hdr(8'h66, 6'h6, 6'h6));
        beat(blk(56'h66, 8'h1a));
        ipg_req_chunk = blk(56'h666, 8'h2a);
        valid_req = 1'b1;
        req_ready = 1'b1;
        step();
        valid_req = 1'b0;
        req_ready = 1'b0;
        chk("t5_drop2", 64'(drop_cnt), 64'd2);
        chk("t5_level3", 64'(fifo_level), 64'd3);
        base = n_popped;
        req_ready = 1'b1;
        drain("t5_drain");
        step();
        chk("t5_popped", 64'(n_popped - base), 64'd3);
        chk("t5_empty", 64'(req_valid), 64'd0);

        // Reset mid-frame discards the partial request.
        do_reset();
        beat(hdr(8'hEE, 6'h1, 6'h2));
        beat(blk(56'hDEAD, 8'h1a));
        do_reset();
        base = n_popped;
        frame(8'h44, 6'h3, 6'h4, 56'hBEEF, 56'hCAFE, 1'b1);
        drain("t6_drain");
        step();
        chk("t6_popped", 64'(n_popped - base), 64'd1);
        chk("t6_err", 64'(frame_err_cnt), 64'd0);
        chk("t6_drop", 64'(drop_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
